wishbone_slave_mem: RTL and testbench
=====================================

# wishbone_slave_mem

Wishbone B4 responder with an internal word-addressed memory, the target end of the Wishbone master used in the example environment. It accepts classic, constant-address and incrementing (linear and wrap) bursts and terminates each beat with ACK, ERR or RTY. It lets the master and the Wishbone UVC be exercised against real storage with registered-feedback burst timing.

## Interface
Parameters:
- WB_ADDR_W, 32, address width (byte address)
- WB_DATA_W, 32, data width; SEL width = WB_DATA_W/8
- WB_TGD_W, 8, data tag width
- WB_TGC_W, 4, cycle tag width (accepted, unused)
- WB_TGA_W, 2, address tag width (accepted, unused)
- MEM_DEPTH, 256, memory words (power of two)
- WAIT_CYCLES, 0, extra wait states before the first ACK of each request

Ports (one clock; reset is asynchronous and active-low):
- CLK_I  in  1  clock
- RST_I  in  1  asynchronous active-low reset
- ADR_I  in  WB_ADDR_W  byte address; word index = ADR_I[log2(MEM_DEPTH)+1:2]
- DAT_I  in  WB_DATA_W  write data
- DAT_O  out  WB_DATA_W  read data, valid with ACK_O
- SEL_I  in  WB_DATA_W/8  byte enables
- WE_I  in  1  1 = write
- STB_I, CYC_I  in  1  strobe, cycle
- LOCK_I  in  1  ignored
- ACK_O, ERR_O, RTY_O  out  1  beat terminations, mutually exclusive
- TGD_I  in  WB_TGD_W  stored with each written word
- TGD_O  out  WB_TGD_W  tag of the word read, valid with ACK_O
- TGA_I  in  WB_TGA_W;  TGC_I  in  WB_TGC_W  ignored
- CTI_I  in  3;  BTE_I  in  2  cycle type / burst type
- busy  in  1  when high at request start, the request is retried

## Operation
- States: IDLE, WAIT, SINGLE, BURST, TERM.
- IDLE: on CYC_I&STB_I: if busy, pulse RTY_O one cycle (no access) and go to TERM. Otherwise latch ADR_I/CTI_I/BTE_I and go to WAIT (WAIT_CYCLES>0) or directly to SINGLE (CTI 000 or 111) or BURST (CTI 001/010).
- WAIT: down-counter; on expiry go to SINGLE or BURST.
- SINGLE: one ACK_O (or ERR_O) pulse, then TERM.
- BURST: ACK_O every cycle while STB_I high; address advanced internally: CTI 001 holds; CTI 010 with BTE 00 adds 4; BTE 01/10/11 wrap inside an aligned 4/8/16-word block (low 2/3/4 word bits increment, upper bits hold). STB_I low: ACK_O low, state and address held. Beat acked with CTI_I==111 ends burst → TERM. CYC_I low → IDLE.
- TERM: outputs low for one cycle, then IDLE.
- Write beat: bytes with SEL_I set written; tag memory takes TGD_I. Read beat: DAT_O/TGD_O from the current word.
- Out-of-range word index (≥ MEM_DEPTH, see Configuration): ERR_O instead of ACK_O, no write, DAT_O=0; a burst ends → TERM.

## Timing
- Reset: ACK_O, ERR_O, RTY_O, DAT_O, TGD_O = 0, state IDLE, counters 0; memory not reset. Reset mid-burst aborts immediately; pending write discarded.
- All outputs registered. Request sampled at edge N; first ACK_O/ERR_O high in the cycle after edge N+1+WAIT_CYCLES. RTY_O is high in the cycle after edge N.
- Burst: zero-wait-state beats after the first; a B-beat burst takes B+1+WAIT_CYCLES cycles.
- Wrap: word index 3 in a 4-beat wrap is followed by index 0 of the same block.
- The write-enable decision uses the current beat's SEL_I/WE_I sampled on the acking edge.
- busy is sampled only in IDLE.

## Configuration
- WB_SLAVE_ERR_EN defined: address bits above the word-index range are checked; any nonzero bit → ERR_O.
- Not defined: ERR_O tied 0; upper bits ignored and memory aliases modulo MEM_DEPTH.

## Structure
- Package wishbone_pkg: CTI_* and BTE_* constants, state enum, and a function returning the wrap mask from BTE.
- Sub-module wb_burst_addr_gen: current word index + CTI + BTE → next word index, purely combinational.

## Test plan
- Classic write 0xDEADBEEF, SEL 1111, addr 0x10, then read 0x10 with WAIT_CYCLES=2 → ACK 3 cycles after STB, DAT_O=0xDEADBEEF.
- Write SEL 0010 data 0x0000AB00 over 0x11223344 → read 0x1122AB44.
- CTI 010, BTE 01, start 0x08, 4-beat read → words 2,3,0,1 on consecutive ACK cycles; last beat CTI 111 → TERM.
- CTI 001, 3 writes 0x1,0x2,0x3 at 0x20 → read 0x20 returns 0x3.
- busy=1 at request → single RTY_O pulse, no ACK, memory unchanged.
- With WB_SLAVE_ERR_EN, MEM_DEPTH 256, read 0x400 → ERR_O, DAT_O=0; without macro → ACK with word 0 contents.

Source files
------------

// File: rtl/wishbone_pkg.sv
// Shared Wishbone B4 definitions: cycle/burst type codes, responder FSM
// states and burst helpers.
package wishbone_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_CONST   = 3'b001;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_END     = 3'b111;

    localparam logic [1:0] BTE_LINEAR  = 2'b00;
    localparam logic [1:0] BTE_WRAP4   = 2'b01;
    localparam logic [1:0] BTE_WRAP8   = 2'b10;
    localparam logic [1:0] BTE_WRAP16  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_SINGLE,
        ST_BURST,
        ST_TERM
    } wb_state_e;

    // Word-index bits that increment inside a wrapping burst; zero for linear.
    function automatic logic [3:0] wrap_mask(input logic [1:0] bte);
        case (bte)
            BTE_WRAP4:  return 4'b0011;
            BTE_WRAP8:  return 4'b0111;
            BTE_WRAP16: return 4'b1111;
            default:    return 4'b0000;
        endcase
    endfunction

    function automatic logic is_burst(input logic [2:0] cti);
        return (cti == CTI_CONST) || (cti == CTI_INCR);
    endfunction

endpackage

// File: rtl/wb_burst_addr_gen.sv
// Next word index for a Wishbone burst: constant, linear or wrapping
// within an aligned 4/8/16-word block. Purely combinational.
module wb_burst_addr_gen
    import wishbone_pkg::*;
#(
    parameter int unsigned IDX_W = 8
) (
    input  logic [IDX_W-1:0] cur_idx,
    input  logic [2:0]       cti,
    input  logic [1:0]       bte,
    output logic [IDX_W-1:0] next_idx
);

    logic [IDX_W-1:0] mask;
    logic [IDX_W-1:0] inc;

    always_comb begin
        mask     = IDX_W'(wrap_mask(bte));
        inc      = cur_idx + IDX_W'(1);
        next_idx = cur_idx;
        if (cti == CTI_INCR) begin
            if (bte == BTE_LINEAR)
                next_idx = inc;
            else
                next_idx = (cur_idx & ~mask) | (inc & mask);
        end
    end

endmodule

// File: rtl/wishbone_slave_mem.sv
// Wishbone B4 responder backed by a word-addressed memory with per-word tags.
// Define WB_SLAVE_ERR_EN to answer ERR_O for addresses beyond MEM_DEPTH words.
module wishbone_slave_mem
    import wishbone_pkg::*;
#(
    parameter int unsigned WB_ADDR_W   = 32,
    parameter int unsigned WB_DATA_W   = 32,
    parameter int unsigned WB_TGD_W    = 8,
    parameter int unsigned WB_TGC_W    = 4,
    parameter int unsigned WB_TGA_W    = 2,
    parameter int unsigned MEM_DEPTH   = 256,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic                   CLK_I,
    input  logic                   RST_I,
    input  logic [WB_ADDR_W-1:0]   ADR_I,
    input  logic [WB_DATA_W-1:0]   DAT_I,
    output logic [WB_DATA_W-1:0]   DAT_O,
    input  logic [WB_DATA_W/8-1:0] SEL_I,
    input  logic                   WE_I,
    input  logic                   STB_I,
    input  logic                   CYC_I,
    input  logic                   LOCK_I,
    output logic                   ACK_O,
    output logic                   ERR_O,
    output logic                   RTY_O,
    input  logic [WB_TGD_W-1:0]    TGD_I,
    output logic [WB_TGD_W-1:0]    TGD_O,
    input  logic [WB_TGA_W-1:0]    TGA_I,
    input  logic [WB_TGC_W-1:0]    TGC_I,
    input  logic [2:0]             CTI_I,
    input  logic [1:0]             BTE_I,
    input  logic                   busy
);

    localparam int unsigned IDX_W = $clog2(MEM_DEPTH);
    localparam int unsigned SEL_W = WB_DATA_W / 8;
    localparam int unsigned CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    logic [WB_DATA_W-1:0] mem     [MEM_DEPTH];
    logic [WB_TGD_W-1:0]  tag_mem [MEM_DEPTH];

    wb_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d, next_idx;
    logic [2:0]       cti_q, cti_d;
    logic [1:0]       bte_q, bte_d;
    logic             addr_err_q, addr_err_d;
    logic             req_err;
    logic             beat, ack_d, err_d, rty_d;
    logic             mem_we, mem_rd;
    logic             unused_inputs;

`ifdef WB_SLAVE_ERR_EN
    assign req_err = |ADR_I[WB_ADDR_W-1:IDX_W+2];
`else
    assign req_err = 1'b0;
`endif

    assign unused_inputs = ^{LOCK_I, TGA_I, TGC_I, ADR_I[1:0], ADR_I[WB_ADDR_W-1:IDX_W+2]};

    wb_burst_addr_gen #(
        .IDX_W (IDX_W)
    ) u_addr_gen (
        .cur_idx  (idx_q),
        .cti      (cti_q),
        .bte      (bte_q),
        .next_idx (next_idx)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        cti_d      = cti_q;
        bte_d      = bte_q;
        addr_err_d = addr_err_q;
        beat       = 1'b0;
        rty_d      = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (CYC_I && STB_I) begin
                    if (busy) begin
                        rty_d   = 1'b1;
                        state_d = ST_TERM;
                    end else begin
                        idx_d      = ADR_I[IDX_W+1:2];
                        cti_d      = CTI_I;
                        bte_d      = BTE_I;
                        addr_err_d = req_err;
                        cnt_d      = (WAIT_CYCLES != 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;
                        if (WAIT_CYCLES != 0)
                            state_d = ST_WAIT;
                        else
                            state_d = is_burst(CTI_I) ? ST_BURST : ST_SINGLE;
                    end
                end
            end
            ST_WAIT: begin
                if (!CYC_I)
                    state_d = ST_IDLE;
                else if (cnt_q == '0)
                    state_d = is_burst(cti_q) ? ST_BURST : ST_SINGLE;
                else
                    cnt_d = cnt_q - CNT_W'(1);
            end
            ST_SINGLE: begin
                beat    = 1'b1;
                state_d = ST_TERM;
            end
            ST_BURST: begin
                if (!CYC_I) begin
                    state_d = ST_IDLE;
                end else if (STB_I) begin
                    beat  = 1'b1;
                    idx_d = next_idx;
                    if (addr_err_q || CTI_I == CTI_END)
                        state_d = ST_TERM;
                end
            end
            ST_TERM: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        ack_d  = beat && !addr_err_q;
        err_d  = beat && addr_err_q;
        mem_we = ack_d && WE_I;
        mem_rd = ack_d && !WE_I;
    end

    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            cti_q      <= '0;
            bte_q      <= '0;
            addr_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            cti_q      <= cti_d;
            bte_q      <= bte_d;
            addr_err_q <= addr_err_d;
        end
    end

    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            ACK_O <= 1'b0;
            ERR_O <= 1'b0;
            RTY_O <= 1'b0;
            DAT_O <= '0;
            TGD_O <= '0;
        end else begin
            ACK_O <= ack_d;
            ERR_O <= err_d;
            RTY_O <= rty_d;
            if (mem_rd) begin
                DAT_O <= mem[idx_q];
                TGD_O <= tag_mem[idx_q];
            end else if (err_d) begin
                DAT_O <= '0;
                TGD_O <= '0;
            end
        end
    end

    // Storage is not reset; the write strobe is already blocked while the FSM sits in reset.
    always_ff @(posedge CLK_I) begin
        if (mem_we) begin
            for (int unsigned b = 0; b < SEL_W; b++) begin
                if (SEL_I[b])
                    mem[idx_q][b*8 +: 8] <= DAT_I[b*8 +: 8];
            end
            tag_mem[idx_q] <= TGD_I;
        end
    end

endmodule

// File: tb/tb_wishbone_slave_mem.sv
// Directed bench for wishbone_slave_mem with two wait states.
module tb_wishbone_slave_mem;

    localparam int WAITS = 2;

    logic        CLK_I = 1'b0;
    logic        RST_I;
    logic [31:0] ADR_I, DAT_I, DAT_O;
    logic [3:0]  SEL_I;
    logic        WE_I, STB_I, CYC_I, LOCK_I;
    logic        ACK_O, ERR_O, RTY_O;
    logic [7:0]  TGD_I, TGD_O;
    logic [1:0]  TGA_I;
    logic [3:0]  TGC_I;
    logic [2:0]  CTI_I;
    logic [1:0]  BTE_I;
    logic        busy;

    int unsigned n_chk = 0;
    int unsigned n_bad = 0;

    logic [31:0] rd;
    logic [7:0]  rtg;
    int          lat;
    logic        got_ack, got_err, got_rty;
    logic [31:0] bd [16];
    logic [31:0] br [16];
    int          bcyc;

    always #5 CLK_I = ~CLK_I;

    wishbone_slave_mem #(
        .WB_ADDR_W   (32),
        .WB_DATA_W   (32),
        .WB_TGD_W    (8),
        .WB_TGC_W    (4),
        .WB_TGA_W    (2),
        .MEM_DEPTH   (256),
        .WAIT_CYCLES (WAITS)
    ) dut (
        .CLK_I  (CLK_I),
        .RST_I  (RST_I),
        .ADR_I  (ADR_I),
        .DAT_I  (DAT_I),
        .DAT_O  (DAT_O),
        .SEL_I  (SEL_I),
        .WE_I   (WE_I),
        .STB_I  (STB_I),
        .CYC_I  (CYC_I),
        .LOCK_I (LOCK_I),
        .ACK_O  (ACK_O),
        .ERR_O  (ERR_O),
        .RTY_O  (RTY_O),
        .TGD_I  (TGD_I),
        .TGD_O  (TGD_O),
        .TGA_I  (TGA_I),
        .TGC_I  (TGC_I),
        .CTI_I  (CTI_I),
        .BTE_I  (BTE_I),
        .busy   (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic wb_single(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                             input logic [3:0] sel, input logic [7:0] tgd);
        @(negedge CLK_I);
        CYC_I = 1'b1; STB_I = 1'b1; WE_I = we; ADR_I = adr; DAT_I = dat;
        SEL_I = sel; TGD_I = tgd; CTI_I = 3'b000; BTE_I = 2'b00;
        lat = 0; got_ack = 1'b0; got_err = 1'b0; got_rty = 1'b0;
        while (!(got_ack || got_err || got_rty) && lat < 20) begin
            @(negedge CLK_I);
            lat++;
            got_ack = ACK_O; got_err = ERR_O; got_rty = RTY_O;
            rd = DAT_O; rtg = TGD_O;
        end
        CYC_I = 1'b0; STB_I = 1'b0; WE_I = 1'b0;
    endtask

    task automatic wb_burst(input logic we, input logic [31:0] adr, input logic [2:0] cti,
                            input logic [1:0] bte, input int n);
        int beats = 0;
        @(negedge CLK_I);
        CYC_I = 1'b1; STB_I = 1'b1; WE_I = we; ADR_I = adr; SEL_I = 4'hF;
        TGD_I = 8'h00; BTE_I = bte; DAT_I = bd[0];
        CTI_I = (n == 1) ? 3'b111 : cti;
        bcyc = 0;
        while (beats < n && bcyc < 40) begin
            @(negedge CLK_I);
            bcyc++;
            if (ACK_O || ERR_O) begin
                br[beats] = DAT_O;
                beats++;
                if (beats < n) begin
                    DAT_I = bd[beats];
                    CTI_I = (beats == n - 1) ? 3'b111 : cti;
                end
            end
        end
        CYC_I = 1'b0; STB_I = 1'b0; WE_I = 1'b0; CTI_I = 3'b000;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        RST_I = 1'b0; CYC_I = 1'b0; STB_I = 1'b0; WE_I = 1'b0; LOCK_I = 1'b0;
        ADR_I = '0; DAT_I = '0; SEL_I = '0; TGD_I = '0; TGA_I = '0; TGC_I = '0;
        CTI_I = '0; BTE_I = '0; busy = 1'b0;
        repeat (3) @(negedge CLK_I);
        check("rst_ack", ACK_O, 0);
        check("rst_err", ERR_O, 0);
        check("rst_rty", RTY_O, 0);
        check("rst_dat", DAT_O, 0);
        check("rst_tgd", TGD_O, 0);
        RST_I = 1'b1;

        wb_single(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 8'h5A);
        check("w1_ack", got_ack, 1);
        check("w1_lat", lat, WAITS + 2);
        wb_single(1'b0, 32'h10, 32'h0, 4'hF, 8'h00);
        check("r1_ack", got_ack, 1);
        check("r1_lat", lat, WAITS + 2);
        check("r1_dat", rd, 32'hDEAD_BEEF);
        check("r1_tgd", rtg, 8'h5A);

        wb_single(1'b1, 32'h14, 32'h1122_3344, 4'hF, 8'h01);
        wb_single(1'b1, 32'h14, 32'h0000_AB00, 4'b0010, 8'h02);
        wb_single(1'b0, 32'h14, 32'h0, 4'hF, 8'h00);
        check("sel_dat", rd, 32'h1122_AB44);
        check("sel_tgd", rtg, 8'h02);

        bd[0] = 32'hA0A0_0000; bd[1] = 32'hA0A0_0001;
        bd[2] = 32'hA0A0_0002; bd[3] = 32'hA0A0_0003;
        wb_burst(1'b1, 32'h00, 3'b010, 2'b00, 4);
        check("lin_cyc", bcyc, 4 + 1 + WAITS);

        wb_burst(1'b0, 32'h08, 3'b010, 2'b01, 4);
        check("wrap_cyc", bcyc, 4 + 1 + WAITS);
        check("wrap_b0", br[0], 32'hA0A0_0002);
        check("wrap_b1", br[1], 32'hA0A0_0003);
        check("wrap_b2", br[2], 32'hA0A0_0000);
        check("wrap_b3", br[3], 32'hA0A0_0001);
        @(negedge CLK_I);
        check("term_ack", ACK_O, 0);

        wb_single(1'b1, 32'h24, 32'h5555_AAAA, 4'hF, 8'h00);
        bd[0] = 32'h1; bd[1] = 32'h2; bd[2] = 32'h3;
        wb_burst(1'b1, 32'h20, 3'b001, 2'b00, 3);
        check("const_cyc", bcyc, 3 + 1 + WAITS);
        wb_single(1'b0, 32'h20, 32'h0, 4'hF, 8'h00);
        check("const_dat", rd, 32'h3);
        wb_single(1'b0, 32'h24, 32'h0, 4'hF, 8'h00);
        check("const_next", rd, 32'h5555_AAAA);

        wb_single(1'b1, 32'h30, 32'hCAFE_F00D, 4'hF, 8'h00);
        busy = 1'b1;
        wb_single(1'b1, 32'h30, 32'h1234_5678, 4'hF, 8'h00);
        busy = 1'b0;
        check("busy_rty", got_rty, 1);
        check("busy_ack", got_ack, 0);
        check("busy_lat", lat, 1);
        @(negedge CLK_I);
        check("busy_rty_pulse", RTY_O, 0);
        wb_single(1'b0, 32'h30, 32'h0, 4'hF, 8'h00);
        check("busy_mem", rd, 32'hCAFE_F00D);

        wb_single(1'b0, 32'h400, 32'h0, 4'hF, 8'h00);
`ifdef WB_SLAVE_ERR_EN
        check("oor_err", got_err, 1);
        check("oor_ack", got_ack, 0);
        check("oor_dat", rd, 32'h0);
`else
        check("oor_ack", got_ack, 1);
        check("oor_err", got_err, 0);
        check("oor_dat", rd, 32'hA0A0_0000);
`endif
        check("oor_lat", lat, WAITS + 2);

        // Reset lands one edge before the first beat of a write burst.
        @(negedge CLK_I);
        CYC_I = 1'b1; STB_I = 1'b1; WE_I = 1'b1; ADR_I = 32'h30; SEL_I = 4'hF;
        DAT_I = 32'h9999_9999; CTI_I = 3'b010; BTE_I = 2'b00;
        repeat (3) @(negedge CLK_I);
        check("abort_pre_ack", ACK_O, 0);
        RST_I = 1'b0;
        @(negedge CLK_I);
        check("abort_ack", ACK_O, 0);
        check("abort_dat", DAT_O, 0);
        CYC_I = 1'b0; STB_I = 1'b0; WE_I = 1'b0; CTI_I = 3'b000;
        @(negedge CLK_I);
        RST_I = 1'b1;
        wb_single(1'b0, 32'h30, 32'h0, 4'hF, 8'h00);
        check("abort_mem", rd, 32'hCAFE_F00D);
        check("abort_ack_after", got_ack, 1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
